// File: rtl/dec_mem_arb.sv
// ============================================================================
// dec_mem_arb : two-requester single-port memory arbiter with clear sweep.
// Macro DEC_MEM_ARB_RR_EN selects round-robin (defined) or fixed priority.
// Revision 1.0
// ============================================================================
`default_nettype none

module dec_mem_arb #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 64,
  parameter int MEM_ADDRW = $clog2(MEM_DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_req,
  input  logic [1:0]             i_we,
  input  logic [2*MEM_ADDRW-1:0] i_addr,
  input  logic [2*MEM_WIDTH-1:0] i_wdata,
  input  logic                   i_clr_start,
  output logic [1:0]             o_gnt,
  output logic [1:0]             o_rvalid,
  output logic [MEM_WIDTH-1:0]   o_rdata,
  output logic                   o_busy,
  output logic                   o_clr_done,
  output logic                   o_mem_wen,
  output logic [MEM_ADDRW-1:0]   o_mem_addr,
  output logic [MEM_WIDTH-1:0]   o_mem_wdata,
  input  logic [MEM_WIDTH-1:0]   i_mem_rdata
);

  typedef enum logic [0:0] {
    IDLE_ARB = 1'b0,
    CLEAR    = 1'b1
  } state_e;

  localparam logic [MEM_ADDRW-1:0] C_LAST_ADDR = MEM_ADDRW'(MEM_DEPTH - 1);
  localparam logic [MEM_ADDRW-1:0] C_ONE       = MEM_ADDRW'(1);

  state_e               state_q, state_d;
  logic [MEM_ADDRW-1:0] cnt_q, cnt_d;
  logic [1:0]           rvalid_q, rvalid_d;
  logic                 done_q, done_d;
  logic [1:0]           gnt;

`ifdef DEC_MEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end
`endif

  // Grant is combinational and forced low while reset is asserted.
  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE_ARB && i_rst_n) begin
`ifdef DEC_MEM_ARB_RR_EN
      if (i_req == 2'b11) begin
        gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = i_req;
      end
`else
      if (i_req[0]) begin
        gnt = 2'b01;
      end else if (i_req[1]) begin
        gnt = 2'b10;
      end
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    rvalid_d = gnt & ~i_we;
    case (state_q)
      IDLE_ARB: begin
        if (i_clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == C_LAST_ADDR) begin
          state_d = IDLE_ARB;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE_ARB;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE_ARB;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (state_q == CLEAR) begin
      o_mem_wen  = 1'b1;
      o_mem_addr = cnt_q;
    end else if (gnt[0]) begin
      o_mem_wen   = i_we[0];
      o_mem_addr  = i_addr[0 +: MEM_ADDRW];
      o_mem_wdata = i_wdata[0 +: MEM_WIDTH];
    end else if (gnt[1]) begin
      o_mem_wen   = i_we[1];
      o_mem_addr  = i_addr[MEM_ADDRW +: MEM_ADDRW];
      o_mem_wdata = i_wdata[MEM_WIDTH +: MEM_WIDTH];
    end
  end

  assign o_gnt      = gnt;
  assign o_rvalid   = rvalid_q;
  assign o_rdata    = i_mem_rdata;
  assign o_busy     = (state_q == CLEAR);
  assign o_clr_done = done_q;

endmodule

`default_nettype wire
